// File: rtl/veririscv_clint.sv
// veriRISCV core-local interruptor: machine timer (mtime/mtimecmp) and msip on an Avalon-MM responder.
// Optional define CLINT_MTIME_SHADOW_EN adds a tear-free high-word shadow for 64-bit mtime reads.
package veririscv_clint_pkg;
  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic [31:0] readdata;
    logic        waitrequest;
  } avalon_resp_t;
endpackage

module veririscv_clint
  import veririscv_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  avalon_req_t  avalon_req,
  output avalon_resp_t avalon_resp,
  output logic         software_interrupt,
  output logic         timer_interrupt
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  localparam logic [15:0] OFF_MSIP       = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP_L = 16'h4000;
  localparam logic [15:0] OFF_MTIMECMP_H = 16'h4004;
  localparam logic [15:0] OFF_MTIME_L    = 16'hBFF8;
  localparam logic [15:0] OFF_MTIME_H    = 16'hBFFC;

  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [31:0] readdata_q, readdata_d;
  logic        timer_irq_q, timer_irq_d;
  logic [31:0] mtime_hi_rd;

  logic        tick;
  logic [15:0] offset;
  logic        wr, rd;
  logic        unused_addr_hi;

  assign offset         = avalon_req.address[15:0];
  assign wr             = avalon_req.write;
  assign rd             = avalon_req.read;
  assign unused_addr_hi = ^avalon_req.address[31:16];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

  assign tick = (tick_cnt_q == TICK_LAST);

`ifdef CLINT_MTIME_SHADOW_EN
  logic [31:0] shadow_q, shadow_d;

  // Low-word reads snapshot the high word so a following high read cannot tear.
  always_comb begin
    shadow_d = shadow_q;
    if (rd && offset == OFF_MTIME_L) shadow_d = mtime_q[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) shadow_q <= '0;
    else     shadow_q <= shadow_d;
  end

  assign mtime_hi_rd = shadow_q;
`else
  assign mtime_hi_rd = mtime_q[63:32];
`endif

  always_comb begin
    tick_cnt_d  = tick ? 16'd0 : tick_cnt_q + 16'd1;
    msip_d      = msip_q;
    mtimecmp_d  = mtimecmp_q;
    mtime_d     = mtime_q;
    readdata_d  = readdata_q;
    timer_irq_d = (mtime_q >= mtimecmp_q);

    if (wr && offset == OFF_MSIP && avalon_req.byte_enable[0]) msip_d = avalon_req.writedata[0];
    if (wr && offset == OFF_MTIMECMP_L)
      mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], avalon_req.writedata, avalon_req.byte_enable);
    if (wr && offset == OFF_MTIMECMP_H)
      mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], avalon_req.writedata, avalon_req.byte_enable);

    // A write to either half freezes the whole counter for that cycle: no increment, no carry.
    if (wr && offset == OFF_MTIME_L)
      mtime_d[31:0] = merge_bytes(mtime_q[31:0], avalon_req.writedata, avalon_req.byte_enable);
    else if (wr && offset == OFF_MTIME_H)
      mtime_d[63:32] = merge_bytes(mtime_q[63:32], avalon_req.writedata, avalon_req.byte_enable);
    else if (tick)
      mtime_d = mtime_q + 64'd1;

    if (rd) begin
      case (offset)
        OFF_MSIP:       readdata_d = {31'd0, msip_q};
        OFF_MTIMECMP_L: readdata_d = mtimecmp_q[31:0];
        OFF_MTIMECMP_H: readdata_d = mtimecmp_q[63:32];
        OFF_MTIME_L:    readdata_d = mtime_q[31:0];
        OFF_MTIME_H:    readdata_d = mtime_hi_rd;
        default:        readdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      readdata_q  <= '0;
      timer_irq_q <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      readdata_q  <= readdata_d;
      timer_irq_q <= timer_irq_d;
    end
  end

  assign avalon_resp.readdata    = readdata_q;
  assign avalon_resp.waitrequest = 1'b0;
  assign software_interrupt      = msip_q;
  assign timer_interrupt         = timer_irq_q;

endmodule

// File: tb/tb_veririscv_clint.sv
// Directed bench for veririscv_clint: two instances (TICK_DIV=1 and TICK_DIV=4) on one clock.
module tb_veririscv_clint;
  import veririscv_clint_pkg::*;

  logic         clk;
  logic         rst;
  avalon_req_t  req1, req4;
  avalon_resp_t resp1, resp4;
  logic         sw1, ti1, sw4, ti4;

  int checks = 0;
  int errors = 0;

  veririscv_clint #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .avalon_req(req1), .avalon_resp(resp1),
    .software_interrupt(sw1), .timer_interrupt(ti1)
  );

  veririscv_clint #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .avalon_req(req4), .avalon_resp(resp4),
    .software_interrupt(sw4), .timer_interrupt(ti4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        chk;
    logic [31:0] exp_rd;
    logic        exp_sw;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Called at a negedge; the request is sampled at the next posedge, and the task returns at the negedge after it.
  task automatic bus_op(input bit use4, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    avalon_req_t r;
    r.read = rd; r.write = wr; r.address = addr; r.writedata = wdata; r.byte_enable = be;
    if (use4) req4 = r;
    else      req1 = r;
    @(negedge clk);
    req1 = '0;
    req4 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    clk  = 1'b0;
    rst  = 1'b1;
    req1 = '0;
    req4 = '0;

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0001, 4'h1, 1'b0, 32'h0,         1'b1, "msip_set"};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_00FF, 4'h0, 1'b0, 32'h0,         1'b1, "msip_be0_nochange"};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 32'h1,         1'b1, "msip_read"};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h0,         4'h1, 1'b1, 32'h1,         1'b0, "msip_rdwr_prewrite"};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 32'h0,         1'b0, "msip_read_cleared"};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_4004, 32'hAABB_CCDD, 4'h4, 1'b0, 32'h0,         1'b0, "cmp_hi_be4_write"};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_4004, 32'h0,         4'h0, 1'b1, 32'hFFBB_FFFF, 1'b0, "cmp_hi_read"};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,         4'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, "cmp_lo_reset_read"};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_4000, 32'h1234_5678, 4'h3, 1'b0, 32'h0,         1'b0, "cmp_lo_be3_write"};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,         4'h0, 1'b1, 32'hFFFF_5678, 1'b0, "cmp_lo_read"};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,         1'b0, "unmapped_write"};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 1'b1, 32'h0,         1'b0, "unmapped_read"};
    vecs[12] = '{1'b1, 1'b0, 32'h1234_4004, 32'h0,         4'h0, 1'b1, 32'hFFBB_FFFF, 1'b0, "upper_addr_ignored"};
    vecs[13] = '{1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,         1'b1, "msip_all_ones"};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 32'h1,         1'b1, "msip_only_bit0"};

    // Free-running mtime with TICK_DIV=1, plus reset values.
    do_reset();
    check("reset_readdata1", resp1.readdata, 32'h0);
    check("reset_waitreq1", resp1.waitrequest, 1'b0);
    check("reset_sw1", sw1, 1'b0);
    check("reset_ti1", ti1, 1'b0);
    check("reset_readdata4", resp4.readdata, 32'h0);
    check("reset_ti4", ti4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ti1", ti1, 1'b0);
      check("idle_sw1", sw1, 1'b0);
    end
    bus_op(1'b0, 1'b1, 1'b0, 32'hBFF8, 32'h0, 4'h0);
    check("div1_mtime_after_10", resp1.readdata, 32'd10);
    bus_op(1'b0, 1'b1, 1'b0, 32'hBFFC, 32'h0, 4'h0);
    check("div1_mtime_hi", resp1.readdata, 32'd0);

    // TICK_DIV=4 prescaler and timer interrupt rise/fall.
    do_reset();
    bus_op(1'b1, 1'b0, 1'b1, 32'hBFF8, 32'h0, 4'hF);
    repeat (15) @(negedge clk);
    bus_op(1'b1, 1'b1, 1'b0, 32'hBFF8, 32'h0, 4'h0);
    check("div4_mtime_16cyc", resp4.readdata, 32'd4);
    bus_op(1'b1, 1'b0, 1'b1, 32'h4004, 32'h0, 4'hF);
    bus_op(1'b1, 1'b0, 1'b1, 32'h4000, 32'd8, 4'hF);
    repeat (13) @(negedge clk);
    check("div4_ti_before_8", ti4, 1'b0);
    @(negedge clk);
    check("div4_ti_at_8", ti4, 1'b1);
    bus_op(1'b1, 1'b0, 1'b1, 32'h4000, 32'h100, 4'hF);
    check("div4_ti_hold_1cyc", ti4, 1'b1);
    @(negedge clk);
    check("div4_ti_cleared", ti4, 1'b0);
    bus_op(1'b1, 1'b1, 1'b0, 32'h4000, 32'h0, 4'h0);
    check("div4_cmp_lo", resp4.readdata, 32'h100);

    // Low-to-high carry with TICK_DIV=1.
    do_reset();
    bus_op(1'b0, 1'b0, 1'b1, 32'hBFF8, 32'hFFFF_FFFE, 4'hF);
    bus_op(1'b0, 1'b0, 1'b1, 32'hBFFC, 32'h0, 4'hF);
    repeat (2) @(negedge clk);
    bus_op(1'b0, 1'b1, 1'b0, 32'hBFF8, 32'h0, 4'h0);
    check("carry_lo", resp1.readdata, 32'h0);
    bus_op(1'b0, 1'b1, 1'b0, 32'hBFFC, 32'h0, 4'h0);
    check("carry_hi", resp1.readdata, 32'h1);

    // Back-to-back low/high read straddling a carry.
    do_reset();
    bus_op(1'b0, 1'b0, 1'b1, 32'hBFFC, 32'h0, 4'hF);
    bus_op(1'b0, 1'b0, 1'b1, 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    bus_op(1'b0, 1'b1, 1'b0, 32'hBFF8, 32'h0, 4'h0);
    check("straddle_lo", resp1.readdata, 32'hFFFF_FFFF);
    bus_op(1'b0, 1'b1, 1'b0, 32'hBFFC, 32'h0, 4'h0);
`ifdef CLINT_MTIME_SHADOW_EN
    check("straddle_hi_shadow", resp1.readdata, 32'h0);
`else
    check("straddle_hi_live", resp1.readdata, 32'h1);
`endif

    // Register access vectors.
    do_reset();
    foreach (vecs[i]) begin
      bus_op(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      if (vecs[i].chk) check({vecs[i].name, "_rd"}, resp1.readdata, vecs[i].exp_rd);
      check({vecs[i].name, "_sw"}, sw1, vecs[i].exp_sw);
      check({vecs[i].name, "_ti"}, ti1, 1'b0);
    end

    // Reset colliding with a read drops the read.
    req1 = '{read: 1'b1, write: 1'b0, address: 32'h0, writedata: 32'h0, byte_enable: 4'h0};
    rst  = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    req1 = '0;
    check("rst_mid_readdata", resp1.readdata, 32'h0);
    check("rst_mid_sw", sw1, 1'b0);
    bus_op(1'b0, 1'b1, 1'b0, 32'h4000, 32'h0, 4'h0);
    check("rst_mid_cmp_lo", resp1.readdata, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
